line_buf_sched: RTL and testbench

// - Scheduler for the WIN_SIZE+1 ring of line buffers used by the sliding-window generator.
// - Selects which buffer the incoming line is written to, and when the stored lines are read.
// - On each read, pops the WIN_SIZE oldest complete lines together and flushes the oldest afterwards.
// - Sits between the input AXI4-Stream handshake and the line_buf instances; it carries no pixel data.

---
 rtl/line_buf_sched.sv | 138 +++++++++++++
 tb/tb_line_buf_sched.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/line_buf_sched.sv
// Line-buffer ring scheduler for the sliding-window generator: chooses the write buffer,
// issues window pops over the WIN_SIZE oldest lines and flushes the oldest after each read.
module line_buf_sched #(
    parameter int WIN_SIZE = 5,
    localparam int BUF_CNT = WIN_SIZE + 1,
    localparam int PTR_W = $clog2(WIN_SIZE + 1)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               wr_beat_i,
    input  logic               wr_sof_i,
    input  logic               wr_eol_i,
    output logic               wr_allow_o,
    output logic [BUF_CNT-1:0] wr_sel_o,
    output logic [BUF_CNT-1:0] pop_o,
    output logic [PTR_W-1:0]   rd_base_o,
    input  logic               rd_done_i,
    output logic [BUF_CNT-1:0] flush_o,
    output logic [PTR_W-1:0]   lines_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {IDLE, FILL, RUN, RESYNC} state_e;

    localparam logic [BUF_CNT-1:0] WIN_MASK = {1'b0, {WIN_SIZE{1'b1}}};

    state_e             state_q, state_d;
    logic [BUF_CNT-1:0] wrPtr_q, wrPtr_d;
    logic [BUF_CNT-1:0] wrSel_q, wrSel_d;
    logic [BUF_CNT-1:0] pop_q, pop_d;
    logic [BUF_CNT-1:0] flush_q, flush_d;
    logic [PTR_W-1:0]   rdBase_q, rdBase_d;
    logic [PTR_W-1:0]   lines_q, lines_d;
    logic               busy_q, busy_d;
    logic               wrAllow_q, wrAllow_d;

    logic beat, sofBeat, eolBeat, lineDone, rdDone;

    function automatic logic [BUF_CNT-1:0] rotl1(input logic [BUF_CNT-1:0] v);
        return {v[BUF_CNT-2:0], v[BUF_CNT-1]};
    endfunction

    // Window covers rd_base..rd_base+WIN_SIZE-1 modulo the ring size.
    function automatic logic [BUF_CNT-1:0] popMask(input logic [PTR_W-1:0] base);
        return (WIN_MASK << base) | (WIN_MASK >> (BUF_CNT - int'(base)));
    endfunction

    assign beat     = wr_beat_i && wrAllow_q;
    assign sofBeat  = beat && wr_sof_i;
    assign eolBeat  = beat && wr_eol_i;
    assign lineDone = eolBeat && (state_q != IDLE || wr_sof_i);
    assign rdDone   = (state_q == RUN) && busy_q && rd_done_i && !sofBeat;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            wrPtr_q   <= BUF_CNT'(1);
            wrSel_q   <= BUF_CNT'(1);
            pop_q     <= '0;
            flush_q   <= '0;
            rdBase_q  <= '0;
            lines_q   <= '0;
            busy_q    <= 1'b0;
            wrAllow_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            wrPtr_q   <= wrPtr_d;
            wrSel_q   <= wrSel_d;
            pop_q     <= pop_d;
            flush_q   <= flush_d;
            rdBase_q  <= rdBase_d;
            lines_q   <= lines_d;
            busy_q    <= busy_d;
            wrAllow_q <= wrAllow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (sofBeat) state_d = FILL;
            FILL: begin
                if (sofBeat)
                    state_d = RESYNC;
                else if (eolBeat && lines_q == PTR_W'(WIN_SIZE - 1))
                    state_d = RUN;
            end
            RUN:     if (sofBeat) state_d = RESYNC;
            RESYNC:  state_d = sofBeat ? RESYNC : FILL;
            default: state_d = IDLE;
        endcase
    end

    // A sof beat restarts the ring before its own eol (if any) is counted.
    always_comb begin
        wrPtr_d  = wrPtr_q;
        rdBase_d = rdBase_q;
        lines_d  = lines_q;
        busy_d   = busy_q;
        pop_d    = '0;
        flush_d  = '0;
        if (sofBeat) begin
            wrPtr_d  = BUF_CNT'(1);
            lines_d  = '0;
            rdBase_d = '0;
            busy_d   = 1'b0;
            if (state_q != IDLE)
                flush_d = '1;
        end
        // pop and busy rise on the same edge, so a second pop cannot slip in behind the first.
        if (rdDone) begin
            flush_d  = BUF_CNT'(1) << rdBase_q;
            rdBase_d = (rdBase_q == PTR_W'(WIN_SIZE)) ? '0 : rdBase_q + 1'b1;
            busy_d   = 1'b0;
        end else if (state_q == RUN && !sofBeat && !busy_q && lines_q >= PTR_W'(WIN_SIZE)) begin
            pop_d  = popMask(rdBase_q);
            busy_d = 1'b1;
        end
        if (lineDone)
            wrPtr_d = rotl1(wrPtr_d);
        if (lineDone && !rdDone)
            lines_d = lines_d + 1'b1;
        else if (!lineDone && rdDone)
            lines_d = lines_q - 1'b1;
        // While full there is no write line; allow returns one cycle after the freeing flush.
        wrAllow_d = (lines_d != PTR_W'(BUF_CNT)) && (lines_q != PTR_W'(BUF_CNT));
        wrSel_d   = wrAllow_d ? wrPtr_d : '0;
    end

    assign wr_allow_o = wrAllow_q;
    assign wr_sel_o   = wrSel_q;
    assign pop_o      = pop_q;
    assign flush_o    = flush_q;
    assign rd_base_o  = rdBase_q;
    assign lines_o    = lines_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_line_buf_sched.sv
// Directed bench for line_buf_sched (WIN_SIZE=5): fill, full ring, wrap, same-cycle
// completion/read, resync and asynchronous reset.
module tb_line_buf_sched;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       wr_beat_i, wr_sof_i, wr_eol_i, rd_done_i;
    logic       wr_allow_o, busy_o;
    logic [5:0] wr_sel_o, pop_o, flush_o;
    logic [2:0] rd_base_o, lines_o;

    int passCnt  = 0;
    int checkCnt = 0;

    logic [5:0] popTab [6] = '{6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F};

    line_buf_sched #(.WIN_SIZE(5)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .wr_beat_i(wr_beat_i), .wr_sof_i(wr_sof_i), .wr_eol_i(wr_eol_i),
        .wr_allow_o(wr_allow_o), .wr_sel_o(wr_sel_o), .pop_o(pop_o),
        .rd_base_o(rd_base_o), .rd_done_i(rd_done_i), .flush_o(flush_o),
        .lines_o(lines_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step(input logic b, input logic s, input logic e, input logic d);
        wr_beat_i = b; wr_sof_i = s; wr_eol_i = e; rd_done_i = d;
        @(posedge clk_i); #1;
        wr_beat_i = 1'b0; wr_sof_i = 1'b0; wr_eol_i = 1'b0; rd_done_i = 1'b0;
    endtask

    task automatic doReset();
        wr_beat_i = 1'b0; wr_sof_i = 1'b0; wr_eol_i = 1'b0; rd_done_i = 1'b0;
        rst_n_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
    endtask

    task automatic fillFive();
        step(1, 1, 0, 0);
        repeat (5) step(1, 0, 1, 0);
    endtask

    task automatic test_reset();
        doReset();
        checkCnt++; if (wr_sel_o !== 6'h01) $display("[TB] FAIL reset_wr_sel: got %h expected %h", wr_sel_o, 6'h01); else passCnt++;
        checkCnt++; if (rd_base_o !== 3'd0) $display("[TB] FAIL reset_rd_base: got %0d expected 0", rd_base_o); else passCnt++;
        checkCnt++; if (lines_o !== 3'd0) $display("[TB] FAIL reset_lines: got %0d expected 0", lines_o); else passCnt++;
        checkCnt++; if (pop_o !== 6'h00) $display("[TB] FAIL reset_pop: got %h expected 00", pop_o); else passCnt++;
        checkCnt++; if (flush_o !== 6'h00) $display("[TB] FAIL reset_flush: got %h expected 00", flush_o); else passCnt++;
        checkCnt++; if (busy_o !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); else passCnt++;
        checkCnt++; if (wr_allow_o !== 1'b1) $display("[TB] FAIL reset_wr_allow: got %b expected 1", wr_allow_o); else passCnt++;
    endtask

    task automatic test_fill();
        logic [5:0] expSel;
        step(1, 0, 1, 0);
        checkCnt++; if (lines_o !== 3'd0) $display("[TB] FAIL idle_no_sof_lines: got %0d expected 0", lines_o); else passCnt++;
        checkCnt++; if (wr_sel_o !== 6'h01) $display("[TB] FAIL idle_no_sof_sel: got %h expected 01", wr_sel_o); else passCnt++;
        step(1, 1, 0, 0);
        checkCnt++; if (wr_sel_o !== 6'h01) $display("[TB] FAIL sof_sel: got %h expected 01", wr_sel_o); else passCnt++;
        for (int k = 1; k <= 5; k++) begin
            step(1, 0, 1, 0);
            expSel = 6'd1 << k;
            checkCnt++; if (wr_sel_o !== expSel) $display("[TB] FAIL fill_sel_%0d: got %h expected %h", k, wr_sel_o, expSel); else passCnt++;
            checkCnt++; if (lines_o !== 3'(k)) $display("[TB] FAIL fill_lines_%0d: got %0d expected %0d", k, lines_o, k); else passCnt++;
            checkCnt++; if (pop_o !== 6'h00) $display("[TB] FAIL fill_no_pop_%0d: got %h expected 00", k, pop_o); else passCnt++;
        end
        step(0, 0, 0, 0);
        checkCnt++; if (pop_o !== 6'h1F) $display("[TB] FAIL first_pop: got %h expected 1F", pop_o); else passCnt++;
        checkCnt++; if (busy_o !== 1'b1) $display("[TB] FAIL first_busy: got %b expected 1", busy_o); else passCnt++;
        checkCnt++; if (rd_base_o !== 3'd0) $display("[TB] FAIL first_rd_base: got %0d expected 0", rd_base_o); else passCnt++;
        step(0, 0, 0, 0);
        checkCnt++; if (pop_o !== 6'h00) $display("[TB] FAIL pop_one_cycle: got %h expected 00", pop_o); else passCnt++;
    endtask

    task automatic test_full();
        step(1, 0, 1, 0);
        checkCnt++; if (lines_o !== 3'd6) $display("[TB] FAIL full_lines: got %0d expected 6", lines_o); else passCnt++;
        checkCnt++; if (wr_allow_o !== 1'b0) $display("[TB] FAIL full_allow: got %b expected 0", wr_allow_o); else passCnt++;
        step(1, 0, 1, 0);
        checkCnt++; if (lines_o !== 3'd6) $display("[TB] FAIL full_ignore_beat: got %0d expected 6", lines_o); else passCnt++;
        step(0, 0, 0, 1);
        checkCnt++; if (flush_o !== 6'h01) $display("[TB] FAIL full_flush: got %h expected 01", flush_o); else passCnt++;
        checkCnt++; if (rd_base_o !== 3'd1) $display("[TB] FAIL full_rd_base: got %0d expected 1", rd_base_o); else passCnt++;
        checkCnt++; if (lines_o !== 3'd5) $display("[TB] FAIL full_lines_dec: got %0d expected 5", lines_o); else passCnt++;
        checkCnt++; if (wr_allow_o !== 1'b0) $display("[TB] FAIL full_allow_lag: got %b expected 0", wr_allow_o); else passCnt++;
        checkCnt++; if ((wr_sel_o & flush_o) !== 6'h00) $display("[TB] FAIL full_sel_flush_overlap: got %h expected 00", wr_sel_o & flush_o); else passCnt++;
        step(0, 0, 0, 0);
        checkCnt++; if (wr_allow_o !== 1'b1) $display("[TB] FAIL full_allow_back: got %b expected 1", wr_allow_o); else passCnt++;
        checkCnt++; if (wr_sel_o !== 6'h01) $display("[TB] FAIL seventh_sel: got %h expected 01", wr_sel_o); else passCnt++;
        checkCnt++; if (pop_o !== 6'h3E) $display("[TB] FAIL second_pop: got %h expected 3E", pop_o); else passCnt++;
        checkCnt++; if (flush_o !== 6'h00) $display("[TB] FAIL flush_one_cycle: got %h expected 00", flush_o); else passCnt++;
    endtask

    task automatic test_wrap();
        logic [5:0] expFlush;
        doReset();
        fillFive();
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0);
            checkCnt++; if (pop_o !== popTab[i % 6]) $display("[TB] FAIL wrap_pop_%0d: got %h expected %h", i, pop_o, popTab[i % 6]); else passCnt++;
            checkCnt++; if (rd_base_o !== 3'(i % 6)) $display("[TB] FAIL wrap_rd_base_%0d: got %0d expected %0d", i, rd_base_o, i % 6); else passCnt++;
            step(1, 0, 1, 0);
            step(0, 0, 0, 1);
            expFlush = 6'd1 << (i % 6);
            checkCnt++; if (flush_o !== expFlush) $display("[TB] FAIL wrap_flush_%0d: got %h expected %h", i, flush_o, expFlush); else passCnt++;
        end
    endtask

    task automatic test_back_to_back();
        doReset();
        fillFive();
        step(0, 0, 0, 0);
        step(1, 0, 1, 1);
        checkCnt++; if (lines_o !== 3'd5) $display("[TB] FAIL b2b_lines: got %0d expected 5", lines_o); else passCnt++;
        checkCnt++; if (wr_sel_o !== 6'h01) $display("[TB] FAIL b2b_wr_sel: got %h expected 01", wr_sel_o); else passCnt++;
        checkCnt++; if (rd_base_o !== 3'd1) $display("[TB] FAIL b2b_rd_base: got %0d expected 1", rd_base_o); else passCnt++;
        checkCnt++; if (flush_o !== 6'h01) $display("[TB] FAIL b2b_flush: got %h expected 01", flush_o); else passCnt++;
        step(0, 0, 0, 0);
        checkCnt++; if (pop_o !== 6'h3E) $display("[TB] FAIL b2b_next_pop: got %h expected 3E", pop_o); else passCnt++;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        checkCnt++; if (rd_base_o !== 3'd2) $display("[TB] FAIL idle_done_ignored: got %0d expected 2", rd_base_o); else passCnt++;
    endtask

    task automatic test_resync();
        doReset();
        fillFive();
        step(1, 1, 0, 0);
        checkCnt++; if (flush_o !== 6'h3F) $display("[TB] FAIL resync_flush: got %h expected 3F", flush_o); else passCnt++;
        checkCnt++; if (pop_o !== 6'h00) $display("[TB] FAIL resync_pop_cancel: got %h expected 00", pop_o); else passCnt++;
        checkCnt++; if (lines_o !== 3'd0) $display("[TB] FAIL resync_lines: got %0d expected 0", lines_o); else passCnt++;
        checkCnt++; if (wr_sel_o !== 6'h01) $display("[TB] FAIL resync_sel: got %h expected 01", wr_sel_o); else passCnt++;
        step(0, 0, 0, 0);
        checkCnt++; if (flush_o !== 6'h00) $display("[TB] FAIL resync_flush_one_cycle: got %h expected 00", flush_o); else passCnt++;
        for (int k = 1; k <= 4; k++) begin
            step(1, 0, 1, 0);
            checkCnt++; if (pop_o !== 6'h00) $display("[TB] FAIL resync_no_pop_%0d: got %h expected 00", k, pop_o); else passCnt++;
        end
        step(0, 0, 0, 0);
        checkCnt++; if (pop_o !== 6'h00) $display("[TB] FAIL resync_four_lines_pop: got %h expected 00", pop_o); else passCnt++;
        checkCnt++; if (wr_sel_o !== 6'h10) $display("[TB] FAIL resync_four_sel: got %h expected 10", wr_sel_o); else passCnt++;
        step(1, 0, 1, 0);
        step(0, 0, 0, 0);
        checkCnt++; if (pop_o !== 6'h1F) $display("[TB] FAIL resync_pop: got %h expected 1F", pop_o); else passCnt++;
        step(1, 1, 1, 0);
        checkCnt++; if (flush_o !== 6'h3F) $display("[TB] FAIL sof_eol_flush: got %h expected 3F", flush_o); else passCnt++;
        checkCnt++; if (lines_o !== 3'd1) $display("[TB] FAIL sof_eol_lines: got %0d expected 1", lines_o); else passCnt++;
        checkCnt++; if (wr_sel_o !== 6'h02) $display("[TB] FAIL sof_eol_sel: got %h expected 02", wr_sel_o); else passCnt++;
        checkCnt++; if (busy_o !== 1'b0) $display("[TB] FAIL sof_eol_busy: got %b expected 0", busy_o); else passCnt++;
    endtask

    task automatic test_async_reset();
        doReset();
        fillFive();
        step(0, 0, 0, 0);
        step(1, 0, 1, 1);
        #2 rst_n_i = 1'b0;
        #1;
        checkCnt++; if (lines_o !== 3'd0) $display("[TB] FAIL async_lines: got %0d expected 0", lines_o); else passCnt++;
        checkCnt++; if (busy_o !== 1'b0) $display("[TB] FAIL async_busy: got %b expected 0", busy_o); else passCnt++;
        checkCnt++; if (wr_sel_o !== 6'h01) $display("[TB] FAIL async_sel: got %h expected 01", wr_sel_o); else passCnt++;
        checkCnt++; if (rd_base_o !== 3'd0) $display("[TB] FAIL async_rd_base: got %0d expected 0", rd_base_o); else passCnt++;
        checkCnt++; if (flush_o !== 6'h00) $display("[TB] FAIL async_flush: got %h expected 00", flush_o); else passCnt++;
        @(posedge clk_i); #1 rst_n_i = 1'b1;
    endtask

    initial begin
        rst_n_i = 1'b1;
        test_reset();
        test_fill();
        test_full();
        test_wrap();
        test_back_to_back();
        test_resync();
        test_async_reset();
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
